// File: rtl/frame_sequencer_pkg.sv
// Shared widths and FSM state encodings for the per-frame render scheduler.
`timescale 1ns/1ps
package frame_sequencer_pkg;

    localparam int VGA_X_W      = 8;
    localparam int VGA_Y_W      = 7;
    localparam int VGA_COLOUR_W = 18;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_TICK    = 3'd1,
        START_GRID   = 3'd2,
        WAIT_GRID    = 3'd3,
        START_PLAYER = 3'd4,
        WAIT_PLAYER  = 3'd5,
        FRAME_DONE   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/frame_sequencer_if.sv
// Pass handshakes plus the two pixel sources and the muxed VGA adapter port.
`timescale 1ns/1ps
interface frame_sequencer_if;
    import frame_sequencer_pkg::*;

    logic                    grid_start;
    logic                    grid_done;
    logic                    player_start;
    logic                    player_done;

    logic [VGA_X_W-1:0]      grid_vga_x;
    logic [VGA_Y_W-1:0]      grid_vga_y;
    logic [VGA_COLOUR_W-1:0] grid_vga_colour;
    logic                    grid_vga_write;

    logic [VGA_X_W-1:0]      player_vga_x;
    logic [VGA_Y_W-1:0]      player_vga_y;
    logic [VGA_COLOUR_W-1:0] player_vga_colour;
    logic                    player_vga_write;

    logic [VGA_X_W-1:0]      vga_x;
    logic [VGA_Y_W-1:0]      vga_y;
    logic [VGA_COLOUR_W-1:0] vga_colour;
    logic                    vga_write;

    modport master (
        output grid_start, player_start,
        output vga_x, vga_y, vga_colour, vga_write,
        input  grid_done, player_done,
        input  grid_vga_x, grid_vga_y, grid_vga_colour, grid_vga_write,
        input  player_vga_x, player_vga_y, player_vga_colour, player_vga_write
    );

    modport slave (
        input  grid_start, player_start,
        input  vga_x, vga_y, vga_colour, vga_write,
        output grid_done, player_done,
        output grid_vga_x, grid_vga_y, grid_vga_colour, grid_vga_write,
        output player_vga_x, player_vga_y, player_vga_colour, player_vga_write
    );

endinterface

// File: rtl/frame_sequencer_timer.sv
// Free-running frame pacer: counts 0..FRAME_CYCLES-1 and flags the last cycle.
`timescale 1ns/1ps
module frame_timer #(
    parameter int FRAME_CYCLES = 833333
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: grid pass, then (with FRAME_SEQUENCER_PLAYER_EN) the
// player-marker pass, with the active pass's pixels routed to the VGA port.
`timescale 1ns/1ps
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int FRAME_CYCLES = 833333,
    parameter int FRAME_CNT_W  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    frame_sequencer_if.master      bus,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   overrun,
    output logic                   busy
);

    seq_state_t state_q;
    seq_state_t state_d;
    logic       tick;
    logic       tick_pending;
    logic       consume;

    frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_frame_timer (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // A tick arriving while an earlier one is still unconsumed is lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            tick_pending <= 1'b0;
            overrun      <= 1'b0;
            frame_count  <= '0;
        end else begin
            state_q      <= state_d;
            tick_pending <= (tick_pending & ~consume) | tick;
            if (tick & tick_pending & ~consume) begin
                overrun <= 1'b1;
            end
            if (state_q == FRAME_DONE) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        consume = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick_pending) begin
                    state_d = START_GRID;
                    consume = 1'b1;
                end
            end
            START_GRID: state_d = WAIT_GRID;
            WAIT_GRID: begin
                if (bus.grid_done) begin
`ifdef FRAME_SEQUENCER_PLAYER_EN
                    state_d = START_PLAYER;
`else
                    state_d = FRAME_DONE;
`endif
                end
            end
`ifdef FRAME_SEQUENCER_PLAYER_EN
            START_PLAYER: state_d = WAIT_PLAYER;
            WAIT_PLAYER: begin
                if (bus.player_done) begin
                    state_d = FRAME_DONE;
                end
            end
`endif
            FRAME_DONE: state_d = WAIT_TICK;
            default:    state_d = IDLE;
        endcase
    end

    // Pixel writes only pass through while their own pass owns the frame.
    always_comb begin
        bus.grid_start   = (state_q == START_GRID);
        bus.player_start = 1'b0;
        bus.vga_x        = '0;
        bus.vga_y        = '0;
        bus.vga_colour   = '0;
        bus.vga_write    = 1'b0;
        busy             = (state_q != IDLE) && (state_q != WAIT_TICK);
        case (state_q)
            START_GRID, WAIT_GRID: begin
                bus.vga_x      = bus.grid_vga_x;
                bus.vga_y      = bus.grid_vga_y;
                bus.vga_colour = bus.grid_vga_colour;
                bus.vga_write  = bus.grid_vga_write;
            end
`ifdef FRAME_SEQUENCER_PLAYER_EN
            START_PLAYER, WAIT_PLAYER: begin
                bus.player_start = (state_q == START_PLAYER);
                bus.vga_x        = bus.player_vga_x;
                bus.vga_y        = bus.player_vga_y;
                bus.vga_colour   = bus.player_vga_colour;
                bus.vga_write    = bus.player_vga_write;
            end
`endif
            default: begin
            end
        endcase
    end

`ifndef FRAME_SEQUENCER_PLAYER_EN
    logic unused_player;
    assign unused_player = ^{bus.player_done, bus.player_vga_x, bus.player_vga_y,
                             bus.player_vga_colour, bus.player_vga_write};
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: a frame-level behavioural model checked every
// cycle, plus literal expectations at hand-computed cycles.
`timescale 1ns/1ps
module tb_frame_sequencer;
    import frame_sequencer_pkg::*;

    localparam int FC    = 100;
    localparam int CNT_W = 4;

`ifdef FRAME_SEQUENCER_PLAYER_EN
    localparam int PLAYER_EN = 1;
    localparam int C_ONE     = 119;
    localparam int C_RESTART = 560;
    localparam int C_DROP    = 614;
    localparam int C_RESET   = 915;
`else
    localparam int PLAYER_EN = 0;
    localparam int C_ONE     = 113;
    localparam int C_RESTART = 554;
    localparam int C_DROP    = 605;
    localparam int C_RESET   = 906;
`endif

    localparam int S_NONE        = -1;
    localparam int S_KICK_GRID   = 0;
    localparam int S_GRID        = 1;
    localparam int S_KICK_PLAYER = 2;
    localparam int S_PLAYER      = 3;
    localparam int S_CLOSE       = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic [CNT_W-1:0] frame_count;
    logic             overrun;
    logic             busy;

    frame_sequencer_if bus ();

    frame_sequencer #(
        .FRAME_CYCLES (FC),
        .FRAME_CNT_W  (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .bus         (bus),
        .frame_count (frame_count),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    int m_cycle   = 0;
    int m_stage   = S_NONE;
    int m_count   = 0;
    bit m_pending = 1'b0;
    bit m_overrun = 1'b0;
    bit m_armed   = 1'b0;
    bit m_valid   = 1'b0;

    int grid_delay   = 10;
    int player_delay = 5;
    bit force_pixel  = 1'b0;
    int first_gs     = -1;
    int gs_count     = 0;
    int ps_count     = 0;
    int gs_mark      = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, m_cycle);
        end
    endtask

    task automatic goto_cycle(input int n);
        while (m_cycle < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic step_to(input int n);
        goto_cycle(n);
        @(negedge clock);
    endtask

    // Frame-level reference: a tick is owed, a frame consumes it, then the
    // passes run in order and the frame is counted on the way out.
    initial begin
        bit tick;
        bit take;
        forever begin
            @(posedge clock);
            if (reset) begin
                m_cycle   = 0;
                m_stage   = S_NONE;
                m_count   = 0;
                m_pending = 1'b0;
                m_overrun = 1'b0;
                m_armed   = 1'b0;
            end else begin
                tick = ((m_cycle % FC) == FC - 1);
                take = (m_stage == S_NONE) && m_armed && enable && m_pending;
                if (tick && m_pending && !take) m_overrun = 1'b1;
                m_pending = (m_pending && !take) || tick;
                case (m_stage)
                    S_NONE: begin
                        if (!m_armed)    m_armed = enable;
                        else if (!enable) m_armed = 1'b0;
                        else if (take)   m_stage = S_KICK_GRID;
                    end
                    S_KICK_GRID:   m_stage = S_GRID;
                    S_GRID:        if (bus.grid_done) m_stage = (PLAYER_EN != 0) ? S_KICK_PLAYER : S_CLOSE;
                    S_KICK_PLAYER: m_stage = S_PLAYER;
                    S_PLAYER:      if (bus.player_done) m_stage = S_CLOSE;
                    default: begin
                        m_count = (m_count + 1) % (1 << CNT_W);
                        m_stage = S_NONE;
                    end
                endcase
                m_cycle++;
            end
            m_valid = 1'b1;
        end
    end

    initial begin
        int ex;
        int ey;
        int ec;
        int ew;
        forever begin
            @(negedge clock);
            if (m_valid) begin
                ex = 0; ey = 0; ec = 0; ew = 0;
                if (m_stage == S_KICK_GRID || m_stage == S_GRID) begin
                    ex = int'(bus.grid_vga_x);   ey = int'(bus.grid_vga_y);
                    ec = int'(bus.grid_vga_colour); ew = int'(bus.grid_vga_write);
                end else if (m_stage == S_KICK_PLAYER || m_stage == S_PLAYER) begin
                    ex = int'(bus.player_vga_x);   ey = int'(bus.player_vga_y);
                    ec = int'(bus.player_vga_colour); ew = int'(bus.player_vga_write);
                end
                check_output("busy", int'(busy), int'(m_stage != S_NONE));
                check_output("grid_start", int'(bus.grid_start), int'(m_stage == S_KICK_GRID));
                check_output("player_start", int'(bus.player_start), int'(m_stage == S_KICK_PLAYER));
                check_output("vga_x", int'(bus.vga_x), ex);
                check_output("vga_y", int'(bus.vga_y), ey);
                check_output("vga_colour", int'(bus.vga_colour), ec);
                check_output("vga_write", int'(bus.vga_write), ew);
                check_output("frame_count", int'(frame_count), m_count);
                check_output("overrun", int'(overrun), int'(m_overrun));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (bus.grid_start === 1'b1) begin
                gs_count++;
                if (first_gs < 0) first_gs = m_cycle;
            end
            if (bus.player_start === 1'b1) ps_count++;
        end
    end

    initial begin
        bus.grid_done = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.grid_start === 1'b1) begin
                repeat (grid_delay) @(posedge clock);
                #1 bus.grid_done = 1'b1;
                @(posedge clock);
                #1 bus.grid_done = 1'b0;
            end
        end
    end

    initial begin
        bus.player_done = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.player_start === 1'b1) begin
                repeat (player_delay) @(posedge clock);
                #1 bus.player_done = 1'b1;
                @(posedge clock);
                #1 bus.player_done = 1'b0;
            end
        end
    end

    // Both pixel sources change every cycle so a wrong mux selection shows up.
    initial begin
        bus.grid_vga_x = '0;   bus.grid_vga_y = '0;   bus.grid_vga_colour = '0;   bus.grid_vga_write = 1'b0;
        bus.player_vga_x = '0; bus.player_vga_y = '0; bus.player_vga_colour = '0; bus.player_vga_write = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            if (force_pixel) begin
                bus.grid_vga_x = 8'd5;   bus.grid_vga_y = 7'd3;   bus.grid_vga_colour = 18'h3FFFF; bus.grid_vga_write = 1'b1;
                bus.player_vga_x = 8'd9; bus.player_vga_y = 7'd9; bus.player_vga_colour = 18'h1;   bus.player_vga_write = 1'b1;
            end else begin
                bus.grid_vga_x        = 8'(m_cycle * 3);
                bus.grid_vga_y        = 7'(m_cycle);
                bus.grid_vga_colour   = 18'(m_cycle * 1000 + 7);
                bus.grid_vga_write    = 1'(m_cycle >> 1);
                bus.player_vga_x      = 8'(255 - m_cycle);
                bus.player_vga_y      = 7'(m_cycle * 5);
                bus.player_vga_colour = 18'(m_cycle * 77 + 3);
                bus.player_vga_write  = 1'(m_cycle);
            end
        end
    end

    task automatic apply_stimulus;
        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_frame_count", int'(frame_count), 0);
        check_output("rst_overrun", int'(overrun), 0);
        check_output("rst_vga_write", int'(bus.vga_write), 0);
        check_output("rst_grid_start", int'(bus.grid_start), 0);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        enable = 1'b1;

        step_to(112);
        check_output("player_start@112", int'(bus.player_start), PLAYER_EN);
        check_output("count_before_first", int'(frame_count), 0);
        step_to(C_ONE);
        check_output("count_first_frame", int'(frame_count), 1);
        step_to(120);
        check_output("first_grid_start_cycle", first_gs, 101);

        goto_cycle(204);
        force_pixel = 1'b1;
        step_to(205);
        check_output("mux_x", int'(bus.vga_x), 5);
        check_output("mux_y", int'(bus.vga_y), 3);
        check_output("mux_colour", int'(bus.vga_colour), 18'h3FFFF);
        check_output("mux_write", int'(bus.vga_write), 1);
        force_pixel = 1'b0;
        step_to(250);
        check_output("idle_vga_write", int'(bus.vga_write), 0);
        check_output("idle_vga_x", int'(bus.vga_x), 0);

        goto_cycle(290);
        grid_delay = 250;
        goto_cycle(310);
        grid_delay = 10;
        step_to(499);
        check_output("overrun_first_miss", int'(overrun), 0);
        step_to(500);
        check_output("overrun_second_miss", int'(overrun), 1);
        step_to(540);
        check_output("long_frame_busy", int'(busy), 1);
        check_output("overrun_sticky", int'(overrun), 1);
        step_to(C_RESTART - 1);
        check_output("count_after_long", int'(frame_count), 3);
        check_output("no_early_grid_start", int'(bus.grid_start), 0);
        step_to(C_RESTART);
        check_output("restart_grid_start", int'(bus.grid_start), 1);

        goto_cycle(C_DROP);
        enable = 1'b0;
        step_to(620);
        check_output("drop_count", int'(frame_count), 5);
        check_output("drop_idle_busy", int'(busy), 0);
        gs_mark = gs_count;
        step_to(900);
        check_output("no_start_when_idle", gs_count, gs_mark);
        enable = 1'b1;
        step_to(902);
        check_output("reenable_grid_start", int'(bus.grid_start), 1);

        step_to(C_RESET);
        check_output("pre_reset_busy", int'(busy), 1);
        check_output("pre_reset_count", int'(frame_count), 5);
        check_output("pre_reset_overrun", int'(overrun), 1);
        reset = 1'b1;
        force_pixel = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_output("post_reset_busy", int'(busy), 0);
        check_output("post_reset_vga_write", int'(bus.vga_write), 0);
        check_output("post_reset_count", int'(frame_count), 0);
        check_output("post_reset_overrun", int'(overrun), 0);
        force_pixel = 1'b0;

        step_to(1550);
        check_output("count_15", int'(frame_count), 15);
        step_to(1600);
        check_output("count_15_hold", int'(frame_count), 15);
        step_to(1650);
        check_output("count_wrap", int'(frame_count), 0);
        step_to(1700);
        check_output("grid_start_total", gs_count, 22);
        check_output("player_start_total", ps_count, (PLAYER_EN != 0) ? 22 : 0);
    endtask

    initial begin
        apply_stimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Top-level per-frame scheduler for the renderer. A frame timer paces the sequence. On each tick it starts the grid pass and waits for its done, then optionally starts the player-marker pass and waits for its done. It multiplexes the active pass's pixel writes onto the single VGA adapter port and reports frame count and overrun status.

## Interface
Parameters:
- FRAME_CYCLES, 833333: clock cycles per frame tick (50 MHz / 60 Hz); must be ≥ 2.
- FRAME_CNT_W, 16: width of frame_count.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- enable  in  1  level. High runs frames. Low stops at the next frame boundary.
- grid_start  out  1  one-cycle pulse that starts the grid pass.
- grid_done  in  1  one-cycle pulse from the grid pass.
- player_start  out  1  one-cycle pulse that starts the player pass.
- player_done  in  1  one-cycle pulse from the player pass.
- grid_vga_x / grid_vga_y / grid_vga_colour / grid_vga_write  in  8/7/18/1  grid pass pixel source.
- player_vga_x / player_vga_y / player_vga_colour / player_vga_write  in  8/7/18/1  player pass pixel source.
- vga_x / vga_y / vga_colour / vga_write  out  8/7/18/1  to the VGA adapter.
- frame_count  out  FRAME_CNT_W  number of completed frames.
- overrun  out  1  sticky; a tick was lost.
- busy  out  1  high in any state other than IDLE and WAIT_TICK.

## Operation
- Frame timer: counter runs 0..FRAME_CYCLES-1 and wraps. It runs regardless of enable. tick is combinational and is high when counter == FRAME_CYCLES-1.
- tick_pending (reg):
  - next = (tick_pending & ~consume) | tick.
  - consume is high when the FSM leaves WAIT_TICK for START_GRID.
- overrun is set when tick & tick_pending & ~consume. It clears only on reset.
- FSM states and transitions:
  - IDLE: enable → WAIT_TICK.
  - WAIT_TICK:
    - ~enable → IDLE.
    - else tick_pending → START_GRID (consume).
  - START_GRID: grid_start=1 → WAIT_GRID.
  - WAIT_GRID: on grid_done → START_PLAYER. With the macro undefined, grid_done → FRAME_DONE instead.
  - START_PLAYER: player_start=1 → WAIT_PLAYER.
  - WAIT_PLAYER: player_done → FRAME_DONE.
  - FRAME_DONE: frame_count += 1, wrapping from all-ones to 0 → WAIT_TICK.
- enable falling mid-frame does not abort the frame. The current frame completes, then WAIT_TICK → IDLE.
- done pulses outside their WAIT state are ignored.
- VGA mux (combinational on state):
  - WAIT_GRID/START_GRID select the grid source.
  - WAIT_PLAYER/START_PLAYER select the player source.
  - Otherwise vga_write=0 and x/y/colour=0.
  - vga_write follows the selected source's write.

## Timing
- Reset values:
  - state IDLE, timer 0, tick_pending 0, overrun 0, frame_count 0.
  - grid_start, player_start, vga_write: 0.
  - vga_x, vga_y, vga_colour: 0.
  - busy: 0.
- Tick at cycle T → tick_pending=1 at T+1.
- With the FSM in WAIT_TICK, START_GRID is in T+2 and grid_start is high for exactly cycle T+2.
- grid_done at cycle D → START_PLAYER at D+1.
- player_done at cycle P → FRAME_DONE at P+1 → frame_count increments at P+2.
- Mux latency: 0 cycles, since the mux is combinational.
- Reset mid-frame returns all state to reset values on the next edge. Already-started passes are not aborted by this block.

## Configuration
- FRAME_SEQUENCER_PLAYER_EN:
  - Defined: the player pass runs after the grid pass.
  - Undefined: START_PLAYER/WAIT_PLAYER are not compiled. player_start is tied 0, player_* inputs are unused, and WAIT_GRID → FRAME_DONE.

## Structure
- Shared package/header: VGA widths (X 8, Y 7, colour 18) and FSM state encodings (3 bits: IDLE 0, WAIT_TICK 1, START_GRID 2, WAIT_GRID 3, START_PLAYER 4, WAIT_PLAYER 5, FRAME_DONE 6).
- One sub-module, frame_timer (parameter FRAME_CYCLES; outputs tick).
- FSM, pending/overrun logic and the mux live in frame_sequencer.

## Test plan
All scenarios use FRAME_CYCLES=100.
- Reset then enable=1; grid_done 10 cycles after grid_start; player_done 5 cycles after player_start.
  - grid_start at cycle 101.
  - player_start follows grid_done by 1 cycle.
  - frame_count=1 two cycles after player_done.
- During WAIT_GRID, grid source writes x=5, y=3, colour=0x3FFFF, write=1.
  - vga_* mirror it.
  - A player_vga_write=1 in the same cycle does not reach vga_write.
- Hold grid_done low for 250 cycles.
  - overrun=1 at the second missed tick and stays 1.
  - The frame still completes.
  - The next grid_start occurs one cycle after returning to WAIT_TICK.
- Drop enable during WAIT_PLAYER.
  - The frame completes and frame_count increments.
  - The FSM reaches IDLE; no further grid_start despite ticks.
- Assert reset during WAIT_PLAYER.
  - Next cycle: busy=0, vga_write=0, frame_count=0, overrun=0.
- FRAME_CNT_W=4 with 16 frames → frame_count wraps 15→0. With the macro undefined, player_start never asserts.
